// File: rtl/axi_lite_mem_nport.sv
// axi_lite_mem_nport: N-port AXI4-Lite bench memory with round-robin arbitration, fixed latencies and tohost exit detection.
// Define MEM_TRACE_EN to $display every granted access.
module axi_lite_mem_nport #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE = '0,
  parameter int MEM_SIZE = 2*1024*1024,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_PORTS-1:0] s_awvalid,
  output logic [NUM_PORTS-1:0] s_awready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_wstrb,
  input  logic [NUM_PORTS-1:0] s_wvalid,
  output logic [NUM_PORTS-1:0] s_wready,
  output logic [NUM_PORTS*2-1:0] s_bresp,
  output logic [NUM_PORTS-1:0] s_bvalid,
  input  logic [NUM_PORTS-1:0] s_bready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_PORTS-1:0] s_arvalid,
  output logic [NUM_PORTS-1:0] s_arready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] s_rdata,
  output logic [NUM_PORTS*2-1:0] s_rresp,
  output logic [NUM_PORTS-1:0] s_rvalid,
  input  logic [NUM_PORTS-1:0] s_rready,
  input  logic [31:0] tohost_addr,
  output logic exit_request,
  output logic [31:0] exit_code
);
  localparam int SW = DATA_WIDTH/8;
  localparam int DEPTH = MEM_SIZE/4;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t st [NUM_PORTS];
  state_t st_n [NUM_PORTS];
  logic [15:0] cnt [NUM_PORTS];
  logic [15:0] cnt_n [NUM_PORTS];
  logic rd_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
  logic [1:0] resp_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_PORTS-1:0] req;
  logic [PW-1:0] rr, gnt;
  logic gnt_vld, sel_rd, in_range, exit_hit;
  logic [ADDR_WIDTH-1:0] addr, off;
  logic [DATA_WIDTH-1:0] wdata, rd_word;
  logic [SW-1:0] wstrb;
  logic [IW-1:0] idx;
  always_comb begin
    req = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      req[p] = st[p] == IDLE && (s_arvalid[p] || (s_awvalid[p] && s_wvalid[p]));
  end
  // Scan downwards so the last hit is the first requester at or after rr.
  always_comb begin
    gnt = rr;
    gnt_vld = 1'b0;
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (req[(int'(rr)+i) % NUM_PORTS]) begin
        gnt = PW'((int'(rr)+i) % NUM_PORTS);
        gnt_vld = !rst;
      end
  end
  always_comb begin
    sel_rd = s_arvalid[gnt];
    addr = sel_rd ? s_araddr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH] : s_awaddr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    wdata = s_wdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    wstrb = s_wstrb[int'(gnt)*SW +: SW];
    off = addr - MEM_BASE;
    in_range = addr >= MEM_BASE && {1'b0, off} < SIZE;
    idx = off[IW+1:2];
    rd_word = in_range ? mem[idx] : '0;
    exit_hit = gnt_vld && !sel_rd && addr == ADDR_WIDTH'(tohost_addr) && wdata[0];
  end
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      st_n[p] = st[p];
      cnt_n[p] = cnt[p];
      if (st[p] == IDLE && gnt_vld && gnt == PW'(p)) begin
        cnt_n[p] = s_arvalid[p] ? 16'(READ_LATENCY-1) : 16'(WRITE_LATENCY-1);
        st_n[p] = cnt_n[p] == 16'd0 ? RESP : WAIT;
      end else if (st[p] == WAIT) begin
        st_n[p] = cnt[p] == 16'd1 ? RESP : WAIT;
        cnt_n[p] = cnt[p] - 16'd1;
      end else if (st[p] == RESP && (rd_q[p] ? s_rready[p] : s_bready[p])) begin
        st_n[p] = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        st[p] <= IDLE;
        cnt[p] <= '0;
        rd_q[p] <= 1'b0;
        rdata_q[p] <= '0;
        resp_q[p] <= 2'b00;
      end
      rr <= '0;
      exit_request <= 1'b0;
      exit_code <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        st[p] <= st_n[p];
        cnt[p] <= cnt_n[p];
        if (gnt_vld && gnt == PW'(p)) begin
          rd_q[p] <= sel_rd;
          resp_q[p] <= in_range ? 2'b00 : 2'b10;
          if (sel_rd) rdata_q[p] <= rd_word;
        end
      end
      if (gnt_vld) rr <= int'(gnt) == NUM_PORTS-1 ? '0 : gnt + 1'b1;
      if (exit_hit && !exit_request) begin
        exit_request <= 1'b1;
        exit_code <= 32'(wdata >> 1);
      end
    end
  end
`ifdef MEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (gnt_vld && !sel_rd && in_range)
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    if (gnt_vld)
      $display("%0t mem p%0d %s addr=%h data=%h strb=%h resp=%0d", $time, gnt, sel_rd ? "R" : "W",
               addr, sel_rd ? rd_word : wdata, sel_rd ? '0 : wstrb, in_range ? 0 : 2);
  end
`else
  always_ff @(posedge clk) begin
    if (gnt_vld && !sel_rd && in_range)
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign s_arready[p] = gnt_vld && gnt == PW'(p) && s_arvalid[p];
    assign s_awready[p] = gnt_vld && gnt == PW'(p) && !s_arvalid[p];
    assign s_wready[p] = s_awready[p];
    assign s_rvalid[p] = st[p] == RESP && rd_q[p];
    assign s_bvalid[p] = st[p] == RESP && !rd_q[p];
    assign s_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    assign s_rresp[p*2 +: 2] = resp_q[p];
    assign s_bresp[p*2 +: 2] = resp_q[p];
  end
endmodule

// File: tb/tb_axi_lite_mem_nport.sv
// tb_axi_lite_mem_nport: random and directed traffic on two ports, scoreboarded against a word-array model.
module tb_axi_lite_mem_nport;
  localparam int NP = 2, AW = 32, RL = 3, WL = 2, MS = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] TOHOST = BASE + 32'h0000_0FF0;
  typedef struct {logic rd; logic [31:0] data; logic [1:0] resp; int due;} exp_t;
  logic clk = 0, rst = 1;
  logic [NP*AW-1:0] s_awaddr, s_araddr;
  logic [NP*32-1:0] s_wdata, s_rdata;
  logic [NP*4-1:0] s_wstrb;
  logic [NP*2-1:0] s_bresp, s_rresp;
  logic [NP-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NP-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] tohost_addr, exit_code;
  logic exit_request;
  logic [31:0] awa [NP], ara [NP], wd [NP];
  logic [3:0] ws [NP];
  logic awv [NP], wv [NP], arv [NP], rrdy [NP], brdy [NP];
  exp_t q [NP][$];
  logic [31:0] ref_mem [int];
  int errs = 0, checks = 0, cyc = 0, rr_m = 0, rdy_mode = 0;
  int hs_cyc [NP];
  logic ex_req = 0, ex_req_n = 0;
  logic [31:0] ex_code = 0, ex_code_n = 0;
  logic seen [NP];
  logic [31:0] held_d [NP], last_rd [NP];
  logic [1:0] held_r [NP], last_rr [NP];
  logic mv;
  logic [31:0] md;
  logic [1:0] mr;
  exp_t me;

  axi_lite_mem_nport #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_BASE(BASE), .MEM_SIZE(MS),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_araddr(s_araddr),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .tohost_addr(tohost_addr),
    .exit_request(exit_request), .exit_code(exit_code));

  always #5 clk = ~clk;
  always_comb
    for (int p = 0; p < NP; p++) begin
      s_awaddr[p*AW +: AW] = awa[p];
      s_araddr[p*AW +: AW] = ara[p];
      s_wdata[p*32 +: 32] = wd[p];
      s_wstrb[p*4 +: 4] = ws[p];
      s_awvalid[p] = awv[p];
      s_wvalid[p] = wv[p];
      s_arvalid[p] = arv[p];
      s_rready[p] = rrdy[p];
      s_bready[p] = brdy[p];
    end
  always @(posedge clk) begin
    cyc++;
    ex_req = ex_req_n;
    ex_code = ex_code_n;
    #1;
    for (int p = 0; p < NP; p++) begin
      rrdy[p] = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      brdy[p] = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a >= BASE && (a - BASE) < 32'(MS);
  endfunction

  task automatic rd(input int p, input logic [31:0] a);
    exp_t e;
    int k;
    ara[p] = a;
    arv[p] = 1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_arready[p]) break;
    end
    chk($sformatf("p%0d ar_handshake", p), 32'(k < 300), 1);
    e.rd = 1;
    e.resp = in_rng(a) ? 2'b00 : 2'b10;
    e.data = in_rng(a) ? ref_mem[int'((a - BASE) >> 2)] : 32'h0;
    e.due = cyc + RL;
    if (k < 300) begin
      q[p].push_back(e);
      hs_cyc[p] = cyc;
      rr_m = (p + 1) % NP;
    end
    @(posedge clk);
    #1 arv[p] = 0;
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int k, i;
    logic [31:0] o;
    awa[p] = a;
    wd[p] = d;
    ws[p] = s;
    awv[p] = 1;
    wv[p] = 1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_awready[p]) break;
    end
    chk($sformatf("p%0d aw_handshake", p), 32'(k < 300), 1);
    chk($sformatf("p%0d wready", p), 32'(s_wready[p]), 32'(s_awready[p]));
    if (k < 300) begin
      if (in_rng(a)) begin
        i = int'((a - BASE) >> 2);
        o = ref_mem.exists(i) ? ref_mem[i] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        ref_mem[i] = o;
      end
      if (a == TOHOST && d[0] && !ex_req_n) begin
        ex_req_n = 1;
        ex_code_n = d >> 1;
      end
      e.rd = 0;
      e.resp = in_rng(a) ? 2'b00 : 2'b10;
      e.data = 32'h0;
      e.due = cyc + WL;
      q[p].push_back(e);
      hs_cyc[p] = cyc;
      rr_m = (p + 1) % NP;
    end
    @(posedge clk);
    #1 awv[p] = 0;
    wv[p] = 0;
  endtask

  task automatic drain;
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 && s_rvalid == 0 && s_bvalid == 0) break;
    end
    chk("drain", 32'(k < 500), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic arb_pair(input logic [31:0] a0, input logic [31:0] a1);
    int f;
    f = rr_m;
    fork
      rd(0, a0);
      rd(1, a1);
    join
    chk($sformatf("arb_second_after_p%0d", f), 32'(hs_cyc[1-f]), 32'(hs_cyc[f] + 1));
    drain();
  endtask

  task automatic rand_port(input int p);
    int r;
    logic [31:0] a;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if (r == 0) a = BASE + 32'(MS) + 32'(4 * $urandom_range(0, 15));
      if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
      if (r < 5) rd(p, a);
      else wr(p, a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) seen[p] = 0;
    end else begin
      chk("exit_request", 32'(exit_request), 32'(ex_req));
      chk("exit_code", exit_code, ex_code);
      for (int p = 0; p < NP; p++) begin
        mv = s_rvalid[p] | s_bvalid[p];
        md = s_rvalid[p] ? s_rdata[p*32 +: 32] : 32'h0;
        mr = s_rvalid[p] ? s_rresp[p*2 +: 2] : s_bresp[p*2 +: 2];
        chk($sformatf("p%0d r_b_exclusive", p), 32'(s_rvalid[p] & s_bvalid[p]), 0);
        if (mv && !seen[p]) begin
          if (q[p].size() == 0) chk($sformatf("p%0d unexpected_resp", p), 32'(mv), 0);
          else begin
            me = q[p].pop_front();
            chk($sformatf("p%0d resp_kind", p), 32'(s_rvalid[p]), 32'(me.rd));
            chk($sformatf("p%0d data", p), md, me.data);
            chk($sformatf("p%0d resp", p), 32'(mr), 32'(me.resp));
            chk($sformatf("p%0d latency_cycle", p), 32'(cyc), 32'(me.due));
            held_d[p] = md;
            held_r[p] = mr;
            if (s_rvalid[p]) begin
              last_rd[p] = md;
              last_rr[p] = mr;
            end
          end
        end else if (mv) begin
          chk($sformatf("p%0d held_data", p), md, held_d[p]);
          chk($sformatf("p%0d held_resp", p), 32'(mr), 32'(held_r[p]));
        end
        seen[p] = mv && !(s_rvalid[p] ? rrdy[p] : brdy[p]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tohost_addr = TOHOST;
    for (int p = 0; p < NP; p++) begin
      awa[p] = 0; ara[p] = 0; wd[p] = 0; ws[p] = 0;
      awv[p] = 0; wv[p] = 0; arv[p] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_wready", 32'(s_wready), 0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_bvalid", 32'(s_bvalid), 0);
    chk("rst_rdata", 32'(s_rdata), 0);
    chk("rst_rresp", 32'(s_rresp), 0);
    chk("rst_bresp", 32'(s_bresp), 0);
    chk("rst_exit_request", 32'(exit_request), 0);
    chk("rst_exit_code", exit_code, 0);
    @(posedge clk);
    #1 rst = 0;
    wr(0, BASE, 32'hDEADBEEF, 4'hF);
    rd(0, BASE);
    drain();
    chk("t1_rdata", last_rd[0], 32'hDEADBEEF);
    chk("t1_rresp", 32'(last_rr[0]), 0);
    rd(1, BASE);
    drain();
    arb_pair(BASE, BASE);
    rd(0, BASE);
    drain();
    arb_pair(BASE, BASE);
    wr(1, BASE + 4, 32'h11223344, 4'hF);
    wr(1, BASE + 4, 32'hAABBCCDD, 4'h5);
    rd(0, BASE + 4);
    drain();
    chk("t3_merge", last_rd[0], 32'h11BB33DD);
    rd(0, BASE + 32'(MS));
    drain();
    chk("t4_oob_rdata", last_rd[0], 0);
    chk("t4_oob_rresp", 32'(last_rr[0]), 2);
    wr(1, BASE + 32'(MS), 32'h12345678, 4'hF);
    wr(0, BASE - 4, 32'h87654321, 4'hF);
    rd(1, BASE);
    drain();
    chk("t4_array_kept", last_rd[1], 32'hDEADBEEF);
    wr(0, TOHOST, 32'h7, 4'hF);
    wr(1, TOHOST, 32'h9, 4'hF);
    rd(0, TOHOST);
    drain();
    chk("t5_exit_request", 32'(exit_request), 1);
    chk("t5_exit_code", exit_code, 3);
    chk("t5_tohost_array", last_rd[0], 32'h9);
    rdy_mode = 2;
    rd(0, BASE + 4);
    repeat (RL + 5) @(negedge clk);
    rdy_mode = 0;
    drain();
    rd(0, BASE);
    rst = 1;
    for (int p = 0; p < NP; p++) q[p].delete();
    rr_m = 0;
    ex_req_n = 0;
    ex_code_n = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_wait_rvalid", 32'(s_rvalid[0]), 0);
    end
    @(posedge clk);
    #1;
    rd(1, BASE + 4);
    drain();
    chk("rst_array_kept", last_rd[1], 32'h11BB33DD);
    arb_pair(BASE, BASE + 4);
    for (int i = 0; i < 8; i++) wr(i % NP, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF);
    drain();
    rdy_mode = 1;
    fork
      rand_port(0);
      rand_port(1);
    join
    drain();
    @(negedge clk);
    rdy_mode = 0;
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
